// File: rtl/h2e_pkt_gate.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | h2e_pkt_gate                                                             |
// | Store-and-forward gate: buffers whole host frames and forwards only      |
// | those with legal byte enables and length <= 2^BYTE_MTU bytes.            |
// | Optional: H2E_PKT_GATE_STATS_EN adds pass_count / drop_count outputs.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module h2e_pkt_gate #(
   parameter int BYTE_MTU  = 10,
   parameter int FIFO_SIZE = 11
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [63:0] s_axis_tdata,
   input  logic [7:0]  s_axis_tkeep,
   input  logic        s_axis_tlast,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   output logic [63:0] m_axis_tdata,
   output logic [7:0]  m_axis_tkeep,
   output logic        m_axis_tlast,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
`ifdef H2E_PKT_GATE_STATS_EN
   output logic [31:0] pass_count,
   output logic [31:0] drop_count,
`endif
   output logic        drop_pulse
);

   localparam int c_pw = FIFO_SIZE + 1;
   localparam int c_cw = BYTE_MTU - 2;
   localparam logic [c_pw-1:0] c_depth     = c_pw'(1) << FIFO_SIZE;
   localparam logic [c_cw-1:0] c_max_beats = c_cw'(1) << (BYTE_MTU - 3);

   // A maximum-size frame must fit in the buffer or the writer can stall forever.
   generate
      if (FIFO_SIZE < BYTE_MTU - 3) begin : g_cfg_check
         $error("h2e_pkt_gate: FIFO_SIZE must be >= BYTE_MTU-3");
      end
   endgenerate

   typedef enum logic [0:0] {
      ST_PASS = 1'b0,
      ST_DROP = 1'b1
   } state_t;

   logic [72:0]     r_mem [0:(1 << FIFO_SIZE)-1];
   logic [c_pw-1:0] r_wr_ptr;
   logic [c_pw-1:0] r_commit_ptr;
   logic [c_pw-1:0] r_rd_ptr;
   logic [c_pw-1:0] r_fetch_ptr;
   logic [c_cw-1:0] r_beat_cnt;
   state_t          r_state;
   logic            r_rst_done;
   logic            r_drop_pulse;
   logic            r_out_valid;
   logic            r_skid_valid;
   logic [72:0]     r_out;
   logic [72:0]     r_skid;

   logic            w_full;
   logic            w_s_ready;
   logic            w_s_acc;
   logic            w_wr_en;
   logic            w_keep_full;
   logic            w_keep_tail;
   logic            w_too_long;
   logic            w_beat_err;
   logic            w_pop;
   logic            w_rd_en;
   logic [72:0]     w_rd_word;

   // rd_ptr only advances on downstream handshake, so beats parked in the
   // output/skid registers still count against buffer occupancy.
   assign w_full      = (r_wr_ptr - r_rd_ptr) == c_depth;
   assign w_s_ready   = r_rst_done & ((r_state == ST_DROP) | ~w_full);
   assign w_s_acc     = s_axis_tvalid & w_s_ready;
   assign w_wr_en     = w_s_acc & (r_state == ST_PASS);
   assign w_keep_full = (s_axis_tkeep == 8'hFF);
   assign w_keep_tail = (s_axis_tkeep != 8'h00) &&
                        ((s_axis_tkeep & (s_axis_tkeep + 8'h01)) == 8'h00);
   assign w_too_long  = (r_beat_cnt >= c_max_beats);
   assign w_beat_err  = w_too_long | (s_axis_tlast ? ~w_keep_tail : ~w_keep_full);

   always_ff @(posedge aclk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr[FIFO_SIZE-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state      <= ST_PASS;
         r_wr_ptr     <= '0;
         r_commit_ptr <= '0;
         r_beat_cnt   <= '0;
         r_drop_pulse <= 1'b0;
         r_rst_done   <= 1'b0;
      end else begin
         r_rst_done   <= 1'b1;
         r_drop_pulse <= 1'b0;
         if (w_s_acc) begin
            case (r_state)
               ST_PASS: begin
                  if (w_beat_err) begin
                     r_wr_ptr   <= r_commit_ptr;
                     r_beat_cnt <= '0;
                     if (s_axis_tlast) r_drop_pulse <= 1'b1;
                     else              r_state      <= ST_DROP;
                  end else begin
                     r_wr_ptr <= r_wr_ptr + c_pw'(1);
                     if (s_axis_tlast) begin
                        r_commit_ptr <= r_wr_ptr + c_pw'(1);
                        r_beat_cnt   <= '0;
                     end else begin
                        r_beat_cnt   <= r_beat_cnt + c_cw'(1);
                     end
                  end
               end
               ST_DROP: begin
                  if (s_axis_tlast) begin
                     r_drop_pulse <= 1'b1;
                     r_state      <= ST_PASS;
                  end
               end
               default: r_state <= ST_PASS;
            endcase
         end
      end
   end

   // Fetch decision depends only on registered skid state, keeping
   // m_axis_tready off the RAM address path.
   assign w_pop     = r_out_valid & m_axis_tready;
   assign w_rd_en   = (r_fetch_ptr != r_commit_ptr) & ~r_skid_valid;
   assign w_rd_word = r_mem[r_fetch_ptr[FIFO_SIZE-1:0]];

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_rd_ptr     <= '0;
         r_fetch_ptr  <= '0;
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
         r_out        <= '0;
         r_skid       <= '0;
      end else begin
         if (w_pop)   r_rd_ptr    <= r_rd_ptr + c_pw'(1);
         if (w_rd_en) r_fetch_ptr <= r_fetch_ptr + c_pw'(1);
         if (w_rd_en) begin
            if (~r_out_valid | w_pop) begin
               r_out       <= w_rd_word;
               r_out_valid <= 1'b1;
            end else begin
               r_skid       <= w_rd_word;
               r_skid_valid <= 1'b1;
            end
         end else if (w_pop) begin
            if (r_skid_valid) begin
               r_out        <= r_skid;
               r_skid_valid <= 1'b0;
            end else begin
               r_out_valid  <= 1'b0;
            end
         end
      end
   end

   assign s_axis_tready = w_s_ready;
   assign m_axis_tdata  = r_out[63:0];
   assign m_axis_tkeep  = r_out[71:64];
   assign m_axis_tlast  = r_out[72];
   assign m_axis_tvalid = r_out_valid;
   assign drop_pulse    = r_drop_pulse;

`ifdef H2E_PKT_GATE_STATS_EN
   logic [31:0] r_pass_count;
   logic [31:0] r_drop_count;
   logic        w_commit;

   assign w_commit = w_wr_en & ~w_beat_err & s_axis_tlast;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_pass_count <= '0;
         r_drop_count <= '0;
      end else begin
         if (w_commit && (r_pass_count != 32'hFFFF_FFFF))     r_pass_count <= r_pass_count + 32'd1;
         if (r_drop_pulse && (r_drop_count != 32'hFFFF_FFFF)) r_drop_count <= r_drop_count + 32'd1;
      end
   end

   assign pass_count = r_pass_count;
   assign drop_count = r_drop_count;
`endif

endmodule
`default_nettype wire
